prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Upstream feeder for the program-memory load port. Accepts a byte stream over a
//  valid/ready handshake and packs each pair of bytes into one 12-bit instruction.
//  Writes each instruction through the PMem load interface (LE/LA/LI), then raises
//  load_done so the controller can leave its LOAD stage.
//  Replaces the fixed file-based program image with runtime loading.
// PARAMETERS
//  ADDR_W   8   program-memory address width
//  INSTR_W  12  instruction width; must be 9..16
//  PROG_LEN 10  instructions per load; 1..2**ADDR_W
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        pulse: begin a load at address 0
//  in_data    in   8        stream byte
//  in_valid   in   1        in_data is valid
//  in_ready   out  1        loader can accept a byte
//  pm_le      out  1        PMem load enable, one cycle per instruction
//  pm_la      out  ADDR_W   PMem load address
//  pm_li      out  INSTR_W  PMem load instruction
//  busy       out  1        load in progress
//  load_done  out  1        all PROG_LEN words written; held high until next start
//  err        out  1        load failed; held high until next start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; address counter 0; checksum accumulator 0.
//  Reset is asynchronous and may arrive mid-load. It aborts the load, and no pm_le
//  pulse follows it.
//  FSM states: IDLE, LO, HI, WRITE, CHECK, DONE, ERR.
//   IDLE/DONE/ERR + start -> LO; clears addr, acc, load_done, err.
//   start is ignored in LO/HI/WRITE/CHECK.
//   LO: in_ready=1; on valid&ready, latch lo=in_data, go to HI.
//   HI: in_ready=1; on valid&ready, latch hi=in_data, go to WRITE.
//   WRITE: exactly one cycle with pm_le=1, pm_la=addr, pm_li={hi[INSTR_W-9:0],lo}.
//    Unused hi bits are ignored. in_ready=0.
//    If addr==PROG_LEN-1: go to CHECK when CHECKSUM_EN is defined, else to DONE.
//    Otherwise addr+1 and go to LO.
//  DONE: load_done=1, busy=0. ERR: err=1, busy=0.
//  busy=1 in LO, HI, WRITE and CHECK.
//  pm_la/pm_li hold their last value outside WRITE; only pm_le qualifies them.
//  Handshake: a byte transfers only when in_valid&in_ready at a clock edge.
//   in_valid may stay low indefinitely (no timeout). Bytes offered in
//   IDLE/DONE/ERR/WRITE are not consumed.
//  Throughput: 3 cycles per instruction at full rate (LO, HI, WRITE).
//  Address never wraps: PROG_LEN bounds it below 2**ADDR_W.
// CONFIGURATION
//  CHECKSUM_EN defined:
//   acc = 8-bit modulo-256 sum of every accepted data byte.
//   After the last WRITE, CHECK asserts in_ready and accepts one more byte, chk.
//   If (acc+chk)&8'hFF==0, go to DONE; otherwise go to ERR.
//  CHECKSUM_EN undefined:
//   No CHECK state and no accumulator. err is tied 0. The stream is exactly
//   2*PROG_LEN bytes.
// STRUCTURE
//  Shared package: loader_state_t enum (IDLE, LO, HI, WRITE, CHECK, DONE, ERR) and
//  localparam BYTES_PER_INSTR=2.
//  Single module; no sub-module is warranted. The FSM, byte latches, address counter
//  and accumulator all live in prog_loader.
// TESTING
//  1 Reset then start; stream 20 bytes (lo=i, hi=8'h0i, i=0..9) at full rate.
//    Expect 10 pm_le pulses, 3 cycles apart.
//    Expect pm_la=0..9 and pm_li={i[3:0],i}. load_done rises the cycle after the
//    10th WRITE.
//  2 Drop in_valid randomly for 0..5 cycles between bytes.
//    Expect the same 10 writes with identical LA/LI values, no duplicates and no
//    extra pulses.
//  3 Assert rst_n=0 between the 4th and 5th instruction.
//    Expect all outputs 0 immediately, and no further pm_le.
//    Restart with start: the first write is at pm_la=0.
//  4 Send hi byte 8'hF3 with lo 8'hA5.
//    Expect pm_li=12'h3A5 (upper nibble ignored). Pulse start during LO: no effect.
//  5 (CHECKSUM_EN) Send the correct two's-complement checksum: expect load_done=1.
//    Repeat with checksum+1: expect err=1 and load_done=0.
//    A following start clears err.
//  6 PROG_LEN=1: 2 bytes give 1 write at pm_la=0, then DONE.
//    Bytes offered in DONE keep in_ready=0 and are not consumed.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types for the program-memory loader: FSM state encoding and packing ratio.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } loader_state_t;

  localparam int BYTES_PER_INSTR = 2;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus the PMem load port (LE/LA/LI) seen by the loader.
interface prog_loader_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               pm_le;
  logic [ADDR_W-1:0]  pm_la;
  logic [INSTR_W-1:0] pm_li;

  modport master (
    output in_data, in_valid,
    input  in_ready, pm_le, pm_la, pm_li
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, pm_le, pm_la, pm_li
  );
endinterface

// File: rtl/prog_loader.sv
// Packs byte pairs from a valid/ready stream into instructions and writes them to PMem.
// Optional trailing checksum byte is enabled by defining CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 12,
  parameter int PROG_LEN = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  prog_loader_if.slave bus,
  output logic         busy_o,
  output logic         load_done_o,
  output logic         err_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

  loader_state_t      state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         lo_q;
  logic               in_ready_q;
  logic               pm_le_q;
  logic [ADDR_W-1:0]  pm_la_q;
  logic [INSTR_W-1:0] pm_li_q;
  logic               busy_q;
  logic               load_done_q;
  logic               take_d;
  logic [INSTR_W-1:0] instr_d;

  assign take_d  = bus.in_valid & in_ready_q;
  // Upper hi-byte bits beyond the instruction width are dropped here.
  assign instr_d = {bus.in_data[INSTR_W-9:0], lo_q};

`ifdef CHECKSUM_EN
  logic [7:0] acc_q;
  logic [7:0] sum_d;
  logic       err_q;

  assign sum_d = acc_q + bus.in_data;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Loader FSM; every output is a register so the PMem port sees clean pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      lo_q        <= 8'h00;
      in_ready_q  <= 1'b0;
      pm_le_q     <= 1'b0;
      pm_la_q     <= '0;
      pm_li_q     <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
`ifdef CHECKSUM_EN
      acc_q       <= 8'h00;
      err_q       <= 1'b0;
`endif
    end else begin
      pm_le_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state_q     <= LO;
            addr_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            load_done_q <= 1'b0;
`ifdef CHECKSUM_EN
            acc_q       <= 8'h00;
            err_q       <= 1'b0;
`endif
          end
        end
        LO: begin
          if (take_d) begin
            lo_q    <= bus.in_data;
            state_q <= HI;
`ifdef CHECKSUM_EN
            acc_q   <= sum_d;
`endif
          end
        end
        HI: begin
          if (take_d) begin
            state_q    <= WRITE;
            in_ready_q <= 1'b0;
            pm_le_q    <= 1'b1;
            pm_la_q    <= addr_q;
            pm_li_q    <= instr_d;
`ifdef CHECKSUM_EN
            acc_q      <= sum_d;
`endif
          end
        end
        WRITE: begin
          if (addr_q == LAST_ADDR) begin
`ifdef CHECKSUM_EN
            state_q     <= CHECK;
            in_ready_q  <= 1'b1;
`else
            state_q     <= DONE;
            busy_q      <= 1'b0;
            load_done_q <= 1'b1;
`endif
          end else begin
            addr_q     <= addr_q + ADDR_W'(1);
            state_q    <= LO;
            in_ready_q <= 1'b1;
          end
        end
`ifdef CHECKSUM_EN
        CHECK: begin
          if (take_d) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (sum_d == 8'h00) begin
              state_q     <= DONE;
              load_done_q <= 1'b1;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.pm_le    = pm_le_q;
  assign bus.pm_la    = pm_la_q;
  assign bus.pm_li    = pm_li_q;
  assign busy_o       = busy_q;
  assign load_done_o  = load_done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a 10-word instance and a 1-word instance.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 12;
  localparam int PLEN    = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic busy0, done0, err0, busy1, done1, err1;

  prog_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus0 ();
  prog_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus1 ();

  prog_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PROG_LEN(PLEN)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .bus(bus0.slave),
    .busy_o(busy0), .load_done_o(done0), .err_o(err0)
  );

  prog_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .PROG_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .bus(bus1.slave),
    .busy_o(busy1), .load_done_o(done1), .err_o(err1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_le = -1;
  bit chk_spacing = 1'b0;
  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every PMem write must match the oldest pending expectation.
  always @(negedge clk) begin : mon
    logic [19:0] e;
    if (bus0.pm_le === 1'b1) begin
      if (exp_q0.size() == 0) begin
        check_val("pm_le0_unexpected", {31'd0, bus0.pm_le}, 32'd0);
      end else begin
        e = exp_q0.pop_front();
        check_val("pm_la0", {24'd0, bus0.pm_la}, {24'd0, e[19:12]});
        check_val("pm_li0", {20'd0, bus0.pm_li}, {20'd0, e[11:0]});
      end
      if (chk_spacing && last_le >= 0) check_val("le_spacing", cyc - last_le, 32'd3);
      last_le = cyc;
    end
    if (bus1.pm_le === 1'b1) begin
      if (exp_q1.size() == 0) begin
        check_val("pm_le1_unexpected", {31'd0, bus1.pm_le}, 32'd0);
      end else begin
        e = exp_q1.pop_front();
        check_val("pm_la1", {24'd0, bus1.pm_la}, {24'd0, e[19:12]});
        check_val("pm_li1", {20'd0, bus1.pm_li}, {20'd0, e[11:0]});
      end
    end
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  task automatic set_valid(input int sel, input logic v, input logic [7:0] b);
    if (sel == 0) begin
      bus0.in_valid = v;
      bus0.in_data  = b;
    end else begin
      bus1.in_valid = v;
      bus1.in_data  = b;
    end
  endtask

  // Returns right after the clock edge that transfers the byte.
  task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      set_valid(sel, 1'b0, 8'h00);
    end
    @(negedge clk);
    set_valid(sel, 1'b1, b);
    n = 0;
    while (rdy(sel) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_val("in_ready_timeout", {31'd0, rdy(sel)}, 32'd1);
    @(posedge clk);
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    set_valid(sel, 1'b0, 8'h00);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic load_prog(input int max_gap, input bit bad_chk);
    logic [7:0] acc, lo, hi, chk;
    acc = 8'h00;
    pulse_start(0);
    last_le = -1;
    for (int i = 0; i < PLEN; i++) begin
      lo = 8'(i);
      hi = 8'(i);
      exp_q0.push_back({8'(i), hi[3:0], lo});
      send_byte(0, lo, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      send_byte(0, hi, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      acc = acc + lo + hi;
    end
`ifdef CHECKSUM_EN
    chk = 8'h00 - acc + {7'd0, bad_chk};
    send_byte(0, chk, 0);
`else
    chk = acc;
`endif
  endtask

  task automatic wait_end(input string tag, input logic exp_done, input logic exp_err);
    int n;
    n = 0;
    while (done0 !== 1'b1 && err0 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done"}, {31'd0, done0}, {31'd0, exp_done});
    check_val({tag, "_err"}, {31'd0, err0}, {31'd0, exp_err});
    check_val({tag, "_busy"}, {31'd0, busy0}, 32'd0);
    check_val({tag, "_pending"}, exp_q0.size(), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    n_errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] acc4, chk1;
    set_valid(0, 1'b0, 8'h00);
    set_valid(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, busy0}, 32'd0);
    check_val("rst_done", {31'd0, done0}, 32'd0);
    check_val("rst_err", {31'd0, err0}, 32'd0);
    check_val("rst_ready", {31'd0, bus0.in_ready}, 32'd0);
    check_val("rst_le", {31'd0, bus0.pm_le}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: full-rate load, pulses 3 cycles apart, done one cycle after last write
    chk_spacing = 1'b1;
    load_prog(0, 1'b0);
`ifndef CHECKSUM_EN
    @(negedge clk);
    check_val("t1_done_during_write", {31'd0, done0}, 32'd0);
    check_val("t1_busy_during_write", {31'd0, busy0}, 32'd1);
    @(negedge clk);
    check_val("t1_done_after_write", {31'd0, done0}, 32'd1);
`endif
    wait_end("t1", 1'b1, 1'b0);
    chk_spacing = 1'b0;

    // 2: random valid gaps
    load_prog(5, 1'b0);
    wait_end("t2", 1'b1, 1'b0);

    // 3: asynchronous reset between the 4th and 5th instruction
    pulse_start(0);
    for (int i = 0; i < 4; i++) begin
      exp_q0.push_back({8'(i), 4'(i), 8'(i)});
      send_byte(0, 8'(i), 0);
      send_byte(0, 8'(i), 0);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("t3_rst_busy", {31'd0, busy0}, 32'd0);
    check_val("t3_rst_ready", {31'd0, bus0.in_ready}, 32'd0);
    check_val("t3_rst_le", {31'd0, bus0.pm_le}, 32'd0);
    check_val("t3_rst_la", {24'd0, bus0.pm_la}, 32'd0);
    check_val("t3_rst_li", {20'd0, bus0.pm_li}, 32'd0);
    check_val("t3_rst_done", {31'd0, done0}, 32'd0);
    set_valid(0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_val("t3_pending", exp_q0.size(), 32'd0);
    check_val("t3_idle_busy", {31'd0, busy0}, 32'd0);
    load_prog(0, 1'b0);
    wait_end("t3", 1'b1, 1'b0);

    // 4: oversized hi byte, and a start pulse in LO that must be ignored
    pulse_start(0);
    exp_q0.push_back({8'd0, 12'h3A5});
    send_byte(0, 8'hA5, 0);
    send_byte(0, 8'hF3, 0);
    acc4 = 8'hA5 + 8'hF3;
    @(negedge clk);
    set_valid(0, 1'b0, 8'h00);
    @(negedge clk);
    check_val("t4_ready_in_lo", {31'd0, bus0.in_ready}, 32'd1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check_val("t4_busy_after_start", {31'd0, busy0}, 32'd1);
    for (int i = 1; i < PLEN; i++) begin
      exp_q0.push_back({8'(i), 4'(i), 8'(8'h10 + i)});
      send_byte(0, 8'(8'h10 + i), 0);
      send_byte(0, 8'(i), 0);
      acc4 = acc4 + 8'(8'h10 + i) + 8'(i);
    end
`ifdef CHECKSUM_EN
    send_byte(0, 8'h00 - acc4, 0);
`endif
    wait_end("t4", 1'b1, 1'b0);

`ifdef CHECKSUM_EN
    // 5: good checksum, bad checksum, then start clears err
    load_prog(0, 1'b0);
    wait_end("t5_good", 1'b1, 1'b0);
    load_prog(0, 1'b1);
    wait_end("t5_bad", 1'b0, 1'b1);
    pulse_start(0);
    check_val("t5_err_cleared", {31'd0, err0}, 32'd0);
    check_val("t5_busy_restart", {31'd0, busy0}, 32'd1);
`endif

    // 6: single-word program; bytes offered in DONE are refused
    pulse_start(1);
    exp_q1.push_back({8'd0, 12'h412});
    send_byte(1, 8'h12, 0);
    send_byte(1, 8'h34, 0);
`ifdef CHECKSUM_EN
    chk1 = 8'h00 - (8'h12 + 8'h34);
    send_byte(1, chk1, 0);
`else
    chk1 = 8'h00;
`endif
    repeat (3) @(negedge clk);
    check_val("t6_done", {31'd0, done1}, 32'd1);
    check_val("t6_pending", exp_q1.size(), 32'd0);
    set_valid(1, 1'b1, 8'h77);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("t6_ready_in_done", {31'd0, bus1.in_ready}, 32'd0);
    end
    check_val("t6_done_held", {31'd0, done1}, 32'd1);
    check_val("t6_busy", {31'd0, busy1}, 32'd0);
    set_valid(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
